// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k for an N x N matrix multiply on one shared MAC unit,
// issuing operand reads, MAC clear/enable and C write-backs. Build macro MATMUL_SEQ_CYCCNT_EN adds cyc_cnt.
`timescale 1ns/1ps
module matmul_sequencer #(
    parameter int N      = 3,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_wr,
    output logic [AW-1:0] c_addr
`ifdef MATMUL_SEQ_CYCCNT_EN
    ,
    output logic [15:0]   cyc_cnt
`endif
);

    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [AW-1:0] N_A      = AW'(N);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic [AW-1:0] caddr;
    } tag_t;

    state_t        state_reg;
    logic [IW-1:0] i_reg;
    logic [IW-1:0] j_reg;
    logic [IW-1:0] k_reg;
    logic          busy_reg;
    logic          done_reg;

    tag_t          pipe_reg [RD_LAT];
    tag_t          tag_next;
    logic [RD_LAT-1:0] stage_valid;

    logic          c_wr_reg;
    logic [AW-1:0] c_addr_reg;

    logic          issue;
    logic          k_wrap;
    logic          j_wrap;
    logic          i_wrap;
    logic          last_issue;
    logic          pipe_busy;
    logic [AW-1:0] c_idx;

    // hold must gate the strobe in the same cycle, so the issue decision is a decode
    assign issue      = (state_reg == ISSUE) && !hold;
    assign k_wrap     = (k_reg == LAST_IDX);
    assign j_wrap     = (j_reg == LAST_IDX);
    assign i_wrap     = (i_reg == LAST_IDX);
    assign last_issue = i_wrap && j_wrap && k_wrap;

    assign a_addr = AW'(i_reg) * N_A + AW'(k_reg);
    assign b_addr = AW'(k_reg) * N_A + AW'(j_reg);
    assign c_idx  = AW'(i_reg) * N_A + AW'(j_reg);

    always_comb begin
        tag_next = '0;
        if (issue) begin
            tag_next.valid = 1'b1;
            tag_next.first = (k_reg == '0);
            tag_next.last  = k_wrap;
            tag_next.caddr = c_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ISSUE;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        k_reg <= k_wrap ? '0 : k_reg + IW'(1);
                        if (k_wrap) begin
                            j_reg <= j_wrap ? '0 : j_reg + IW'(1);
                            if (j_wrap) begin
                                i_reg <= i_wrap ? '0 : i_reg + IW'(1);
                            end
                        end
                        if (last_issue) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // the final write is registered on this same edge, so only the read pipeline matters
                    if (!pipe_busy) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // tags travel alongside the operand reads so the MAC stage knows clear/last/address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int st = 0; st < RD_LAT; st++) begin
                pipe_reg[st] <= '0;
            end
            c_wr_reg   <= 1'b0;
            c_addr_reg <= '0;
        end else begin
            pipe_reg[0] <= tag_next;
            for (int st = 1; st < RD_LAT; st++) begin
                pipe_reg[st] <= pipe_reg[st-1];
            end
            c_wr_reg <= pipe_reg[RD_LAT-1].valid && pipe_reg[RD_LAT-1].last;
            if (pipe_reg[RD_LAT-1].valid && pipe_reg[RD_LAT-1].last) begin
                c_addr_reg <= pipe_reg[RD_LAT-1].caddr;
            end
        end
    end

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage_valid
        assign stage_valid[gi] = pipe_reg[gi].valid;
    end

    assign pipe_busy = |stage_valid;

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = issue;
    assign mac_en  = pipe_reg[RD_LAT-1].valid;
    assign mac_clr = pipe_reg[RD_LAT-1].valid && pipe_reg[RD_LAT-1].first;
    assign c_wr    = c_wr_reg;
    assign c_addr  = c_addr_reg;

`ifdef MATMUL_SEQ_CYCCNT_EN
    logic [15:0] cyc_cnt_reg;

    // counts every cycle spent outside IDLE, so after done it equals the start-to-done latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                cyc_cnt_reg <= '0;
            end
        end else if (cyc_cnt_reg != 16'hFFFF) begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
        end
    end

    assign cyc_cnt = cyc_cnt_reg;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: table-driven start/hold stimulus, a run-level event model,
// and an attached MAC/register-file harness checking the resulting C matrix.
`timescale 1ns/1ps
module tb_matmul_sequencer;

    localparam int N      = 3;
    localparam int AW     = 4;
    localparam int RD_LAT = 1;
    localparam int NN     = N * N;
    localparam int MAXC   = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hold;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          c_wr;
    logic [AW-1:0] c_addr;
`ifdef MATMUL_SEQ_CYCCNT_EN
    logic [15:0]   cyc_cnt;
`endif

    matmul_sequencer #(.N(N), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hold    (hold),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .c_wr    (c_wr),
        .c_addr  (c_addr)
`ifdef MATMUL_SEQ_CYCCNT_EN
        ,
        .cyc_cnt (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // stimulus tables, indexed by cycle
    bit start_tab [MAXC];
    bit hold_tab  [MAXC];

    // expected per-cycle outputs
    bit e_rd   [MAXC];
    bit e_mac  [MAXC];
    bit e_clr  [MAXC];
    bit e_cwr  [MAXC];
    bit e_done [MAXC];
    bit e_busy [MAXC];
    int e_a    [MAXC];
    int e_b    [MAXC];
    int e_caddr[MAXC];
    int e_cnt  [MAXC];

    int idle_from = 0;
    int plan_done = 0;

    // observations of the DUT for literal checks
    int rd_cyc_q[$];
    int rd_a_q[$];
    int rd_b_q[$];
    int cwr_cyc_q[$];
    int cwr_addr_q[$];
    int done_q[$];

    // attached operand/result storage and MAC
    int amem [NN];
    int bmem [NN];
    int cmem [NN];
    int prodq[$];
    int acc = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Expected events of one run started at cycle s: one operation per non-held cycle in
    // row-major i/j/k order, MAC RD_LAT later, write one cycle after the last k.
    function automatic int plan_run(input int s);
        int c;
        int last;
        int d;
        int ii;
        int jj;
        int kk;
        c    = s + 1;
        last = c;
        for (int n = 0; n < N * N * N; n++) begin
            ii = n / (N * N);
            jj = (n / N) % N;
            kk = n % N;
            while (hold_tab[c] && c < MAXC - 16) c++;
            e_rd[c] = 1'b1;
            e_a[c]  = ii * N + kk;
            e_b[c]  = kk * N + jj;
            e_mac[c + RD_LAT] = 1'b1;
            e_clr[c + RD_LAT] = (kk == 0);
            if (kk == N - 1) begin
                e_cwr[c + RD_LAT + 1]   = 1'b1;
                e_caddr[c + RD_LAT + 1] = ii * N + jj;
            end
            last = c;
            c++;
        end
        d = last + RD_LAT + 2;
        for (int t = s + 1; t < d; t++) e_busy[t] = 1'b1;
        e_done[d] = 1'b1;
        for (int t = s + 1; t < MAXC; t++) e_cnt[t] = (t <= d + 1) ? (t - s - 1) : (d - s);
        idle_from = d + 1;
        return d;
    endfunction

    function automatic void clear_exp(input int from);
        for (int t = from; t < MAXC; t++) begin
            e_rd[t] = 0; e_mac[t] = 0; e_clr[t] = 0; e_cwr[t] = 0;
            e_done[t] = 0; e_busy[t] = 0; e_a[t] = 0; e_b[t] = 0;
            e_caddr[t] = 0; e_cnt[t] = 0;
        end
    endfunction

    function automatic void clear_tabs(input int from);
        for (int t = from; t < MAXC; t++) begin
            start_tab[t] = 1'b0;
            hold_tab[t]  = 1'b0;
        end
    endfunction

    task automatic clear_obs();
        rd_cyc_q.delete(); rd_a_q.delete(); rd_b_q.delete();
        cwr_cyc_q.delete(); cwr_addr_q.delete(); done_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = start_tab[cyc];
        hold  = hold_tab[cyc];
        if (!rst && start_tab[cyc] && cyc >= idle_from) begin
            plan_done = plan_run(cyc);
            $display("run start cycle %0d expected done cycle %0d", cyc, plan_done);
        end
    endtask

    task automatic launch(input int s);
        while (cyc < s) step();
    endtask

    task automatic run_until_idle();
        int guard;
        guard = 0;
        while (cyc < plan_done + 2 && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic check_c();
        int r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                r = 0;
                for (int k = 0; k < N; k++) r += amem[i * N + k] * bmem[k * N + j];
                chk("c_matrix", cmem[i * N + j], r);
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rd_en"}, rd_en, 0);
        chk({nm, "_a_addr"}, a_addr, 0);
        chk({nm, "_b_addr"}, b_addr, 0);
        chk({nm, "_mac_en"}, mac_en, 0);
        chk({nm, "_mac_clr"}, mac_clr, 0);
        chk({nm, "_c_wr"}, c_wr, 0);
        chk({nm, "_c_addr"}, c_addr, 0);
`ifdef MATMUL_SEQ_CYCCNT_EN
        chk({nm, "_cyc_cnt"}, cyc_cnt, 0);
`endif
    endtask

    // per-cycle comparison against the model, plus observation logging
    always @(negedge clk) begin
        if (!rst && chk_on && cyc < MAXC) begin
            chk("rd_en", rd_en, e_rd[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("mac_en", mac_en, e_mac[cyc]);
            chk("mac_clr", mac_clr, e_clr[cyc]);
            chk("c_wr", c_wr, e_cwr[cyc]);
            if (e_rd[cyc]) begin
                chk("a_addr", a_addr, e_a[cyc]);
                chk("b_addr", b_addr, e_b[cyc]);
            end
            if (e_cwr[cyc]) chk("c_addr", c_addr, e_caddr[cyc]);
`ifdef MATMUL_SEQ_CYCCNT_EN
            chk("cyc_cnt", cyc_cnt, e_cnt[cyc]);
`endif
            if (rd_en) begin
                rd_cyc_q.push_back(cyc);
                rd_a_q.push_back(int'(a_addr));
                rd_b_q.push_back(int'(b_addr));
            end
            if (c_wr) begin
                cwr_cyc_q.push_back(cyc);
                cwr_addr_q.push_back(int'(c_addr));
            end
            if (done) done_q.push_back(cyc);
        end
    end

    // MAC harness: operands arrive RD_LAT cycles after rd_en, accumulator is registered
    always @(negedge clk) begin
        if (rst) begin
            prodq.delete();
            acc = 0;
        end else begin
            if (c_wr) cmem[c_addr] = acc;
            if (mac_en) begin
                if (prodq.size() == 0) begin
                    chk("operand_available", 0, 1);
                end else begin
                    acc = mac_clr ? prodq.pop_front() : acc + prodq.pop_front();
                end
            end
            if (rd_en) prodq.push_back(amem[a_addr] * bmem[b_addr]);
        end
    end

    initial begin
        int s;
        int s2;
        int pct;
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        clear_tabs(0);
        clear_exp(0);
        @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        idle_from = cyc;
        chk_on    = 1'b1;

        // identity A, B = 1..9, no hold
        for (int t = 0; t < NN; t++) begin
            amem[t] = (t / N == t % N) ? 1 : 0;
            bmem[t] = t + 1;
            cmem[t] = -1;
        end
        clear_tabs(cyc + 1);
        clear_obs();
        s = cyc + 2;
        start_tab[s] = 1'b1;
        launch(s);
        run_until_idle();
        chk("rd_count", rd_cyc_q.size(), 27);
        chk("first_rd_cycle", rd_cyc_q[0] - s, 1);
        chk("rd0_a", rd_a_q[0], 0);
        chk("rd0_b", rd_b_q[0], 0);
        chk("rd1_a", rd_a_q[1], 1);
        chk("rd1_b", rd_b_q[1], 3);
        chk("rd2_a", rd_a_q[2], 2);
        chk("rd2_b", rd_b_q[2], 6);
        chk("cwr_count", cwr_cyc_q.size(), 9);
        chk("first_cwr_cycle", cwr_cyc_q[0] - s, 5);
        chk("last_cwr_cycle", cwr_cyc_q[cwr_cyc_q.size() - 1] - s, 29);
        for (int t = 0; t < cwr_addr_q.size(); t++) chk("cwr_order", cwr_addr_q[t], t);
        chk("done_count", done_q.size(), 1);
        chk("done_cycle", done_q[0] - s, 30);
        for (int t = 0; t < NN; t++) chk("c_identity", cmem[t], t + 1);

        // all-255 operands; start re-asserted at +5 and +30 (ignored), +31 (new run)
        for (int t = 0; t < NN; t++) begin
            amem[t] = 255;
            bmem[t] = 255;
            cmem[t] = -1;
        end
        clear_tabs(cyc + 1);
        clear_obs();
        s = cyc + 2;
        start_tab[s] = 1'b1;
        start_tab[s + 5] = 1'b1;
        start_tab[s + 30] = 1'b1;
        start_tab[s + 31] = 1'b1;
        launch(s + 31);
        run_until_idle();
        chk("done_count_restart", done_q.size(), 2);
        chk("done_cycle_run1", done_q[0] - s, 30);
        chk("done_cycle_run2", done_q[1] - s, 61);
        chk("cwr_count_restart", cwr_cyc_q.size(), 18);
        for (int t = 0; t < NN; t++) chk("c_all255", cmem[t], 195075);

        // four hold cycles starting at +10
        for (int t = 0; t < NN; t++) begin
            amem[t] = $urandom_range(0, 255);
            bmem[t] = $urandom_range(0, 255);
            cmem[t] = -1;
        end
        clear_tabs(cyc + 1);
        clear_obs();
        s = cyc + 2;
        start_tab[s] = 1'b1;
        for (int t = 10; t < 14; t++) hold_tab[s + t] = 1'b1;
        launch(s);
        run_until_idle();
        cnt = 0;
        foreach (rd_cyc_q[q]) if (rd_cyc_q[q] >= s + 10 && rd_cyc_q[q] <= s + 13) cnt++;
        chk("rd_during_hold", cnt, 0);
        chk("rd_count_hold", rd_cyc_q.size(), 27);
        chk("done_cycle_hold", done_q[0] - s, 34);
        for (int t = 0; t < cwr_addr_q.size(); t++) chk("cwr_order_hold", cwr_addr_q[t], t);
        check_c();
`ifdef MATMUL_SEQ_CYCCNT_EN
        chk("cyc_cnt_after_done", cyc_cnt, 34);
        repeat (3) step();
        chk("cyc_cnt_held", cyc_cnt, 34);
        s2 = cyc + 1;
        start_tab[s2] = 1'b1;
        launch(s2);
        step();
        chk("cyc_cnt_restart", cyc_cnt, 0);
        run_until_idle();
`endif

        // randomized runs: random operands, hold density and spurious starts
        for (int r = 0; r < 10; r++) begin
            for (int t = 0; t < NN; t++) begin
                amem[t] = $urandom_range(0, 255);
                bmem[t] = $urandom_range(0, 255);
                cmem[t] = -1;
            end
            clear_tabs(cyc + 1);
            clear_obs();
            s   = cyc + 1 + $urandom_range(1, 4);
            pct = $urandom_range(0, 40);
            for (int t = cyc + 1; t < s + 150; t++) hold_tab[t] = ($urandom_range(0, 99) < pct);
            start_tab[s] = 1'b1;
            for (int q = 0; q < 3; q++) start_tab[s + 1 + $urandom_range(0, 28)] = 1'b1;
            launch(s);
            run_until_idle();
            chk("rand_done_count", done_q.size(), 1);
            chk("rand_cwr_count", cwr_cyc_q.size(), NN);
            check_c();
        end

        // asynchronous reset part-way through a run, then a clean run
        for (int t = 0; t < NN; t++) begin
            amem[t] = $urandom_range(0, 255);
            bmem[t] = $urandom_range(0, 255);
            cmem[t] = -1;
        end
        clear_tabs(cyc + 1);
        clear_obs();
        s = cyc + 2;
        start_tab[s] = 1'b1;
        launch(s + 15);
        chk("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        clear_exp(cyc);
        clear_tabs(cyc + 1);
        step();
        step();
        rst       = 1'b0;
        idle_from = cyc;
        clear_obs();
        for (int t = 0; t < NN; t++) cmem[t] = -1;
        s2 = cyc + 2;
        start_tab[s2] = 1'b1;
        launch(s2);
        run_until_idle();
        chk("post_reset_done_count", done_q.size(), 1);
        chk("post_reset_done_cycle", done_q[0] - s2, 30);
        check_c();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
